// File: rtl/param_seq_fsm.sv
// Parametrised cyclic sequencer: NUM_STATES states, one branch/abort point, Mealy output window.
// Define PARAM_SEQ_FSM_OUT_REG_EN to register outp (one-cycle lag, glitch-free).
module param_seq_fsm #(
    parameter int NUM_STATES   = 8,
    parameter int B_W          = 3,
    parameter int BRANCH_STATE = 3,
    parameter int OUT_START    = 2,
    parameter int OUT_END      = 3,
    parameter int CNT_W        = 8,
    localparam int STATE_W     = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [B_W-1:0]     b,
    input  logic [B_W-1:0]     branch_mask,
    input  logic [B_W-1:0]     out_mask,
    output logic               outp,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   done_cnt,
    output logic [CNT_W-1:0]   abort_cnt
);

    generate
        if (NUM_STATES < 2 || NUM_STATES > 256) begin : g_bad_num_states
            $error("param_seq_fsm: NUM_STATES must be in 2..256");
        end
        if (BRANCH_STATE < 0 || BRANCH_STATE >= NUM_STATES) begin : g_bad_branch
            $error("param_seq_fsm: BRANCH_STATE must be < NUM_STATES");
        end
        if (OUT_START < 0 || OUT_START > OUT_END || OUT_END >= NUM_STATES) begin : g_bad_window
            $error("param_seq_fsm: need 0 <= OUT_START <= OUT_END < NUM_STATES");
        end
        if (B_W < 1 || CNT_W < 1) begin : g_bad_width
            $error("param_seq_fsm: B_W and CNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        XFER_HOLD,
        XFER_STEP,
        XFER_DONE,
        XFER_ABORT,
        XFER_RESYNC
    } xfer_e;

    localparam logic [STATE_W-1:0] LAST_S   = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W-1:0] BRANCH_S = STATE_W'(BRANCH_STATE);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   done_q, done_d;
    logic [CNT_W-1:0]   abort_q, abort_d;
    logic               branch_taken;
    logic               state_legal;
    logic               in_window;
    logic               outp_comb;
    xfer_e              xfer;

    assign branch_taken = |(b & branch_mask);
    assign state_legal  = int'(state_q) < NUM_STATES;
    assign in_window    = (int'(state_q) >= OUT_START) && (int'(state_q) <= OUT_END);
    assign outp_comb    = state_legal && in_window && (|(b & out_mask));

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        xfer    = XFER_HOLD;
        state_d = state_q;
        if (en) begin
            if (!state_legal) begin
                xfer    = XFER_RESYNC;
                state_d = '0;
            end else if (state_q == BRANCH_S) begin
                if (!branch_taken) begin
                    xfer    = XFER_ABORT;
                    state_d = '0;
                end else if (BRANCH_S == LAST_S) begin
                    xfer    = XFER_DONE;
                    state_d = '0;
                end else begin
                    xfer    = XFER_STEP;
                    state_d = state_q + STATE_W'(1);
                end
            end else if (state_q == LAST_S) begin
                xfer    = XFER_DONE;
                state_d = '0;
            end else begin
                xfer    = XFER_STEP;
                state_d = state_q + STATE_W'(1);
            end
        end
    end

    // Counters saturate; only one transition kind exists per edge, so at most one moves.
    always_comb begin
        done_d  = done_q;
        abort_d = abort_q;
        if (xfer == XFER_DONE && done_q != CNT_MAX) begin
            done_d = done_q + CNT_W'(1);
        end
        if (xfer == XFER_ABORT && abort_q != CNT_MAX) begin
            abort_d = abort_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
            done_q  <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

`ifdef PARAM_SEQ_FSM_OUT_REG_EN
    logic outp_q;

    // Sampled every edge, independent of en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outp_q <= 1'b0;
        end else begin
            outp_q <= outp_comb;
        end
    end

    assign outp = outp_q;
`else
    assign outp = outp_comb;
`endif

    assign state     = state_q;
    assign done_cnt  = done_q;
    assign abort_cnt = abort_q;

endmodule

// File: tb/tb_param_seq_fsm.sv
// Self-checking bench for param_seq_fsm: three instances against a sequence-level model.
// Honours PARAM_SEQ_FSM_OUT_REG_EN for the expected outp timing.
module tb_param_seq_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] b;
    logic [2:0] branch_mask;
    logic [2:0] out_mask;

    logic       outp0, outp_s, outp5;
    logic [2:0] st0, st_s, st5;
    logic [7:0] dn0, ab0, dn5, ab5;
    logic [1:0] dn_s, ab_s;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    param_seq_fsm dut (
        .clk(clk), .rst_n(rst_n), .en(en), .b(b), .branch_mask(branch_mask), .out_mask(out_mask),
        .outp(outp0), .state(st0), .done_cnt(dn0), .abort_cnt(ab0)
    );

    param_seq_fsm #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .b(b), .branch_mask(branch_mask), .out_mask(out_mask),
        .outp(outp_s), .state(st_s), .done_cnt(dn_s), .abort_cnt(ab_s)
    );

    param_seq_fsm #(.NUM_STATES(5), .BRANCH_STATE(4)) u_ns5 (
        .clk(clk), .rst_n(rst_n), .en(en), .b(b), .branch_mask(branch_mask), .out_mask(out_mask),
        .outp(outp5), .state(st5), .done_cnt(dn5), .abort_cnt(ab5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sequence-level model: position advances modulo the length, a refused branch restarts it.
    typedef struct {
        int st;
        int dn;
        int ab;
        bit oreg;
    } mdl_t;

    mdl_t m0, ms, m5;

    function automatic bit mealy(input int st, input int os, input int oe);
        return (st >= os) && (st <= oe) && (|(b & out_mask));
    endfunction

    function automatic mdl_t step(input mdl_t m, input int ns, input int br, input int cmax);
        mdl_t n = m;
        if (!rst_n) begin
            n = '{default: 0};
            return n;
        end
        n.oreg = mealy(m.st, 2, 3);
        if (en) begin
            if (m.st == br && !(|(b & branch_mask))) begin
                n.st = 0;
                n.ab = (m.ab < cmax) ? m.ab + 1 : cmax;
            end else if (m.st + 1 == ns) begin
                n.st = 0;
                n.dn = (m.dn < cmax) ? m.dn + 1 : cmax;
            end else begin
                n.st = m.st + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 = step(m0, 8, 3, 255);
        ms = step(ms, 8, 3, 3);
        m5 = step(m5, 5, 4, 255);
    end

    function automatic bit exp_outp(input mdl_t m);
`ifdef PARAM_SEQ_FSM_OUT_REG_EN
        return m.oreg;
`else
        return mealy(m.st, 2, 3);
`endif
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("cmp_state", 32'(st0), 32'(m0.st));
            check("cmp_done", 32'(dn0), 32'(m0.dn));
            check("cmp_abort", 32'(ab0), 32'(m0.ab));
            check("cmp_outp", 32'(outp0), 32'(exp_outp(m0)));
            check("cmp_sat_state", 32'(st_s), 32'(ms.st));
            check("cmp_sat_done", 32'(dn_s), 32'(ms.dn));
            check("cmp_sat_abort", 32'(ab_s), 32'(ms.ab));
            check("cmp_sat_outp", 32'(outp_s), 32'(exp_outp(ms)));
            check("cmp_ns5_state", 32'(st5), 32'(m5.st));
            check("cmp_ns5_done", 32'(dn5), 32'(m5.dn));
            check("cmp_ns5_abort", 32'(ab5), 32'(m5.ab));
            check("cmp_ns5_outp", 32'(outp5), 32'(exp_outp(m5)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit win(input int st);
        return (st == 2) || (st == 3);
    endfunction

    initial begin
        logic [2:0] hold_b [5];
        logic [2:0] bv;
        int prev;
        int exp_s;
        bit eo;
        hold_b = '{3'b000, 3'b001, 3'b100, 3'b011, 3'b110};
        m0 = '{default: 0};
        ms = '{default: 0};
        m5 = '{default: 0};
        rst_n = 1'b0;
        en = 1'b1;
        b = 3'b111;
        branch_mask = 3'b010;
        out_mask = 3'b011;

        // Reset held for two edges with en=1
        tick();
        started = 1'b1;
        tick();
        check("rst_state", 32'(st0), 0);
        check("rst_done", 32'(dn0), 0);
        check("rst_abort", 32'(ab0), 0);
        check("rst_outp", 32'(outp0), 0);
        rst_n = 1'b1;
        en = 1'b0;
        tick();
        check("rst_release_state", 32'(st0), 0);

        // Full pass
        en = 1'b1;
        b = 3'b010;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_s = (i + 1) % 8;
            check("pass_state", 32'(st0), 32'(exp_s));
`ifdef PARAM_SEQ_FSM_OUT_REG_EN
            eo = win(prev);
`else
            eo = win(exp_s);
`endif
            check("pass_outp", 32'(outp0), 32'(eo));
            if (i < 5) check("ns5_state", 32'(st5), 32'((i + 1) % 5));
            prev = exp_s;
        end
        check("pass_done", 32'(dn0), 1);
        check("pass_abort", 32'(ab0), 0);
        check("ns5_done", 32'(dn5), 1);

        // Abort passes
        b = 3'b101;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_state", 32'(st0), 32'((i + 1) % 4));
            if (i == 3) check("abort_cnt1", 32'(ab0), 1);
        end
        check("abort_cnt2", 32'(ab0), 2);
        check("abort_done", 32'(dn0), 1);
        check("ns5_abort", 32'(ab5), 2);

        // Hold at state 2
        b = 3'b010;
        tick();
        tick();
        check("hold_entry", 32'(st0), 2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bv = hold_b[i];
            b = bv;
            #1;
`ifndef PARAM_SEQ_FSM_OUT_REG_EN
            check("hold_outp_comb", 32'(outp0), 32'(|(bv & 3'b011)));
`endif
            tick();
`ifdef PARAM_SEQ_FSM_OUT_REG_EN
            check("hold_outp_reg", 32'(outp0), 32'(|(bv & 3'b011)));
`endif
            check("hold_state", 32'(st0), 2);
            check("hold_done", 32'(dn0), 1);
            check("hold_abort", 32'(ab0), 2);
        end

        // Saturation on the CNT_W=2 instance
        en = 1'b1;
        b = 3'b010;
        repeat (6) tick();
        check("pass2_done", 32'(dn0), 2);
        check("sat_pass2", 32'(dn_s), 2);
        for (int p = 3; p <= 5; p++) begin
            repeat (8) tick();
            check("sat_done", 32'(dn_s), 3);
            check("dut_done_unsat", 32'(dn0), 32'(p));
        end
        check("sat_abort", 32'(ab_s), 2);

        // Mid-run reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        en = 1'b0;
        tick();
        check("rerun_state", 32'(st0), 0);
        check("rerun_done", 32'(dn0), 0);
        en = 1'b1;
        repeat (21) tick();
        check("midrst_pre_state", 32'(st0), 5);
        check("midrst_pre_done", 32'(dn0), 2);
        rst_n = 1'b0;
        tick();
        check("midrst_state", 32'(st0), 0);
        check("midrst_done", 32'(dn0), 0);
        check("midrst_abort", 32'(ab0), 0);
        rst_n = 1'b1;
        en = 1'b0;
        tick();
        en = 1'b1;
        repeat (5) tick();
        check("ns5_wrap_state", 32'(st5), 0);
        check("ns5_wrap_done", 32'(dn5), 1);
        check("midrst_after", 32'(st0), 5);
        check("midrst_after_done", 32'(dn0), 0);

        @(negedge clk);
        started = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
